// File: rtl/cfg_loader.sv
// cfg_loader: fetches per-layer configuration descriptors from memory,
// writes them into the compute block's config registers, and then holds
// the layer start level until the compute side reports the layer done.
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for i_go; latches base address and layer count
//   S_FETCH | 4 read cycles, word k = 0..3 of the current layer descriptor
//   S_DRAIN | one cycle that writes the last word read in S_FETCH
//   S_RUN   | o_start held high until i_layer_done
//   S_DONE  | one-cycle o_done pulse, then back to S_IDLE
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous active-low reset
//   i_go           job start, only honoured in S_IDLE
//   i_base_addr    word address of the layer 0 descriptor
//   i_num_layers   number of layers in the job (0 = empty job)
//   i_layer_done   layer-complete pulse, only honoured in S_RUN
//   o_mem_rd_en    memory read strobe
//   o_mem_rd_addr  memory read address (wraps modulo 1024)
//   i_mem_rd_data  memory read data, valid the cycle after the strobe
//   o_cfg          config write data (read data passed straight through)
//   o_cfg_addr     config register index 0..3
//   o_cfg_wr_en    config write strobe
//   o_start        layer start level
//   o_busy         high whenever not in S_IDLE
//   o_done         one-cycle job-complete pulse
//   o_layer_idx    current layer, 0 while idle or done

module cfg_loader (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_go,
  input  logic [9:0]  i_base_addr,
  input  logic [3:0]  i_num_layers,
  input  logic        i_layer_done,
  output logic        o_mem_rd_en,
  output logic [9:0]  o_mem_rd_addr,
  input  logic [15:0] i_mem_rd_data,
  output logic [15:0] o_cfg,
  output logic [1:0]  o_cfg_addr,
  output logic        o_cfg_wr_en,
  output logic        o_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_layer_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  base_q, base_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  layer_q, layer_d;
  logic [1:0]  k_q, k_d;

  // A read issued in S_FETCH returns its data one cycle later; these two
  // flops remember that a write is due and which config index it targets.
  logic        wr_pend_q;
  logic [1:0]  wr_k_q;

  logic [4:0]  layer_inc;
  logic [9:0]  layer_offs;

  assign layer_inc  = {1'b0, layer_q} + 5'd1;
  assign layer_offs = {4'd0, layer_q, 2'b00} + {8'd0, k_q};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      layer_q   <= '0;
      k_q       <= '0;
      wr_pend_q <= 1'b0;
      wr_k_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      layer_q   <= layer_d;
      k_q       <= k_d;
      wr_pend_q <= (state_q == S_FETCH);
      wr_k_q    <= k_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    layer_d       = layer_q;
    k_d           = k_q;
    o_mem_rd_en   = 1'b0;
    o_mem_rd_addr = '0;
    o_start       = 1'b0;
    o_done        = 1'b0;
    o_layer_idx   = '0;

    case (state_q)
      S_IDLE: begin
        if (i_go) begin
          base_d  = i_base_addr;
          count_d = i_num_layers;
          layer_d = '0;
          k_d     = '0;
          state_d = (i_num_layers == 4'd0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        o_mem_rd_en   = 1'b1;
        // 10-bit sum, so the descriptor address wraps modulo 1024.
        o_mem_rd_addr = base_q + layer_offs;
        o_layer_idx   = layer_q;
        k_d           = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        o_layer_idx = layer_q;
        state_d     = S_RUN;
      end

      S_RUN: begin
        o_start     = 1'b1;
        o_layer_idx = layer_q;
        if (i_layer_done) begin
          if (layer_inc < {1'b0, count_q}) begin
            layer_d = layer_inc[3:0];
            k_d     = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_cfg_wr_en = wr_pend_q;
    o_cfg_addr  = wr_pend_q ? wr_k_q : 2'd0;
    o_cfg       = wr_pend_q ? i_mem_rd_data : 16'd0;
  end

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_cfg_loader.sv
module tb_cfg_loader;

  logic        i_clk;
  logic        i_rst;
  logic        i_go;
  logic [9:0]  i_base_addr;
  logic [3:0]  i_num_layers;
  logic        i_layer_done;
  logic        o_mem_rd_en;
  logic [9:0]  o_mem_rd_addr;
  logic [15:0] i_mem_rd_data;
  logic [15:0] o_cfg;
  logic [1:0]  o_cfg_addr;
  logic        o_cfg_wr_en;
  logic        o_start;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_layer_idx;

  cfg_loader dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_go          (i_go),
    .i_base_addr   (i_base_addr),
    .i_num_layers  (i_num_layers),
    .i_layer_done  (i_layer_done),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_rd_addr (o_mem_rd_addr),
    .i_mem_rd_data (i_mem_rd_data),
    .o_cfg         (o_cfg),
    .o_cfg_addr    (o_cfg_addr),
    .o_cfg_wr_en   (o_cfg_wr_en),
    .o_start       (o_start),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_layer_idx   (o_layer_idx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  logic [15:0] mem [0:1023];
  logic [9:0]  exp_rd [$];
  logic [17:0] exp_wr [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: data one cycle after the strobe, garbage otherwise so
  // that any ungated passthrough shows up on o_cfg.
  always @(posedge i_clk) begin
    if (o_mem_rd_en) i_mem_rd_data <= mem[o_mem_rd_addr];
    else             i_mem_rd_data <= 16'($urandom);
  end

  // Scoreboard side: every read and write is popped from the expected queues.
  always @(negedge i_clk) begin
    if (o_done) done_cnt++;
    if (o_mem_rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", {22'd0, o_mem_rd_addr}, 32'h3ff_ffff);
      else chk("rd_addr", {22'd0, o_mem_rd_addr}, {22'd0, exp_rd.pop_front()});
    end else begin
      chk("rd_addr_idle", {22'd0, o_mem_rd_addr}, 32'd0);
    end
    if (o_cfg_wr_en) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", {14'd0, o_cfg_addr, o_cfg}, 32'hfff_ffff);
      else chk("wr_word", {14'd0, o_cfg_addr, o_cfg}, {14'd0, exp_wr.pop_front()});
    end else begin
      chk("wr_idle", {14'd0, o_cfg_addr, o_cfg}, 32'd0);
    end
  end

  task automatic push_layer(input logic [9:0] base, input int l);
    logic [9:0] a;
    for (int k = 0; k < 4; k++) begin
      a = base + 10'(4 * l + k);
      exp_rd.push_back(a);
      exp_wr.push_back({2'(k), mem[a]});
    end
  endtask

  task automatic wait_start(input bit noise, input logic [9:0] base, input logic [3:0] cnt);
    int cyc;
    cyc = 0;
    while (o_start !== 1'b1 && cyc < 20) begin
      if (noise && cyc == 1) begin
        i_go = 1'b1; i_base_addr = base ^ 10'h155; i_num_layers = 4'hf; i_layer_done = 1'b1;
      end
      if (noise && cyc == 2) begin
        i_go = 1'b0; i_base_addr = base; i_num_layers = cnt; i_layer_done = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    chk("start_latency", cyc, 5);
  endtask

  task automatic run_job(input logic [9:0] base, input logic [3:0] cnt, input bit noise);
    int d0;
    d0 = done_cnt;
    for (int l = 0; l < int'(cnt); l++) push_layer(base, l);
    i_base_addr = base; i_num_layers = cnt; i_go = 1'b1;
    @(negedge i_clk);
    i_go = 1'b0;
    if (cnt == 4'd0) begin
      chk("done_after_go", {31'd0, o_done}, 1);
      chk("busy_in_done", {31'd0, o_busy}, 1);
      chk("no_start_empty", {31'd0, o_start}, 0);
    end else begin
      for (int l = 0; l < int'(cnt); l++) begin
        chk("fetch_rd_en", {31'd0, o_mem_rd_en}, 1);
        chk("fetch_layer_idx", {28'd0, o_layer_idx}, 32'(l));
        wait_start(noise, base, cnt);
        repeat (2) @(negedge i_clk);
        chk("run_start_held", {31'd0, o_start}, 1);
        chk("run_layer_idx", {28'd0, o_layer_idx}, 32'(l));
        chk("run_busy", {31'd0, o_busy}, 1);
        i_layer_done = 1'b1;
        @(negedge i_clk);
        i_layer_done = 1'b0;
        chk("start_drop", {31'd0, o_start}, 0);
      end
      chk("done_pulse", {31'd0, o_done}, 1);
      chk("done_layer_idx", {28'd0, o_layer_idx}, 0);
    end
    @(negedge i_clk);
    chk("done_single", {31'd0, o_done}, 0);
    chk("idle_busy", {31'd0, o_busy}, 0);
    #1;
    chk("done_count", done_cnt - d0, 1);
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {o_mem_rd_en, o_mem_rd_addr, o_cfg_wr_en, o_cfg_addr, o_start, o_busy, o_done, o_layer_idx},
        32'd0);
    chk({tag, "_cfg"}, {16'd0, o_cfg}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom) | 16'h0001;
    mem[64] = 16'h0204; mem[65] = 16'h0201; mem[66] = 16'h0200; mem[67] = 16'h0040;
    i_rst = 1'b0; i_go = 1'b0; i_base_addr = '0; i_num_layers = '0; i_layer_done = 1'b0;
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset_state");
    i_rst = 1'b1;
    @(negedge i_clk);
    i_layer_done = 1'b1;
    @(negedge i_clk);
    i_layer_done = 1'b0;
    chk_all_zero("idle_ignores_layer_done");

    run_job(10'd64, 4'd1, 1'b0);
    run_job(10'd0, 4'd3, 1'b0);
    run_job(10'd0, 4'd0, 1'b0);
    run_job(10'd1022, 4'd1, 1'b0);
    run_job(10'd200, 4'd2, 1'b1);

    // Abort in RUN: only layer 0 is expected before reset hits.
    push_layer(10'd300, 0);
    i_base_addr = 10'd300; i_num_layers = 4'd2; i_go = 1'b1;
    @(negedge i_clk);
    i_go = 1'b0;
    cyc = 0;
    while (o_start !== 1'b1 && cyc < 20) begin
      @(negedge i_clk);
      cyc++;
    end
    chk("abort_start_latency", cyc, 5);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk_all_zero("reset_in_run");
    i_rst = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) @(negedge i_clk);
    chk_all_zero("post_reset_idle");
    run_job(10'd500, 4'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
